// File: rtl/button_updown_reader.sv
// button_updown_reader: two active-low push-buttons (UP, DOWN) step a 3-bit
// value up/down modulo 8, with synchronising, debouncing, press-edge detection,
// auto-repeat while held, and a lockout while both buttons are held.
// Button index 0 = UP, index 1 = DOWN throughout.
module button_updown_reader #(
  parameter int unsigned DEBOUNCE_CYC     = 270_000,
  parameter int unsigned REPEAT_DELAY_CYC = 13_500_000,
  parameter int unsigned REPEAT_RATE_CYC  = 5_400_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up_n,
  input  logic       btn_dn_n,
  output logic [2:0] value,
  output logic       step_pulse,
  output logic       step_dir
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned REP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                    REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT,
    ST_LOCKED
  } btn_state_e;

  // Synchroniser chain, debounced levels and the previous debounced level
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] stable_q, stable_d;
  logic [1:0] stable_prev_q, stable_prev_d;

  logic [DB_W-1:0]  db_cnt_q  [2];
  logic [DB_W-1:0]  db_cnt_d  [2];
  logic [REP_W-1:0] rep_cnt_q [2];
  logic [REP_W-1:0] rep_cnt_d [2];
  btn_state_e       state_q   [2];
  btn_state_e       state_d   [2];

  logic [2:0] value_q, value_d;
  logic       pulse_q, pulse_d;
  logic       dir_q, dir_d;

  logic [1:0] press_ev;
  logic [1:0] release_ev;
  logic [1:0] step_req;
  logic       both_low;

  // Synchroniser and debounce next-state
  always_comb begin
    sync1_d       = {btn_dn_n, btn_up_n};
    sync2_d       = sync1_q;
    stable_prev_d = stable_q;
    stable_d      = stable_q;
    for (int unsigned i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Edge events are taken from the registered level so steps land one cycle
  // after the debounced level changes.
  always_comb begin
    press_ev   = stable_prev_q & ~stable_q;
    release_ev = ~stable_prev_q & stable_q;
    both_low   = ~stable_q[0] & ~stable_q[1];
  end

  // Per-button press / auto-repeat / lockout FSM next-state
  always_comb begin
    step_req = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      state_d[i]   = state_q[i];
      rep_cnt_d[i] = rep_cnt_q[i];
      if (both_low) begin
        state_d[i] = ST_LOCKED;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (press_ev[i]) begin
              step_req[i]  = 1'b1;
              rep_cnt_d[i] = '0;
              state_d[i]   = ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (release_ev[i]) begin
              state_d[i] = ST_IDLE;
            end else if (rep_cnt_q[i] == DELAY_LAST) begin
              step_req[i]  = 1'b1;
              rep_cnt_d[i] = '0;
              state_d[i]   = ST_REPEAT;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
            end
          end
          ST_REPEAT: begin
            if (release_ev[i]) begin
              state_d[i] = ST_IDLE;
            end else if (rep_cnt_q[i] == RATE_LAST) begin
              step_req[i]  = 1'b1;
              rep_cnt_d[i] = '0;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
            end
          end
          ST_LOCKED: begin
            if (release_ev[i]) begin
              state_d[i] = ST_IDLE;
            end
          end
          default: state_d[i] = ST_IDLE;
        endcase
      end
    end
  end

  // Value stepping; simultaneous UP and DOWN requests cancel
  always_comb begin
    value_d = value_q;
    dir_d   = dir_q;
    pulse_d = 1'b0;
    if (step_req[0] && !step_req[1]) begin
      value_d = value_q + 3'd1;
      dir_d   = 1'b1;
      pulse_d = 1'b1;
    end else if (step_req[1] && !step_req[0]) begin
      value_d = value_q - 3'd1;
      dir_d   = 1'b0;
      pulse_d = 1'b1;
    end
  end

  // All state registers, cleared asynchronously to the released/idle state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      stable_q      <= '1;
      stable_prev_q <= '1;
      for (int unsigned i = 0; i < 2; i++) begin
        db_cnt_q[i]  <= '0;
        rep_cnt_q[i] <= '0;
        state_q[i]   <= ST_IDLE;
      end
      value_q <= '0;
      pulse_q <= 1'b0;
      dir_q   <= 1'b1;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      for (int unsigned i = 0; i < 2; i++) begin
        db_cnt_q[i]  <= db_cnt_d[i];
        rep_cnt_q[i] <= rep_cnt_d[i];
        state_q[i]   <= state_d[i];
      end
      value_q <= value_d;
      pulse_q <= pulse_d;
      dir_q   <= dir_d;
    end
  end

  assign value      = value_q;
  assign step_pulse = pulse_q;
  assign step_dir   = dir_q;

endmodule

// File: tb/tb_button_updown_reader.sv
// Testbench for button_updown_reader with short debounce/repeat timings.
// A timestamp-based reference model predicts value/step_pulse/step_dir.
module tb_button_updown_reader;

  localparam int unsigned D  = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RR = 8;

  logic       clk;
  logic       rst;
  logic       btn_up_n;
  logic       btn_dn_n;
  logic [2:0] value;
  logic       step_pulse;
  logic       step_dir;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  button_updown_reader #(
    .DEBOUNCE_CYC     (D),
    .REPEAT_DELAY_CYC (RD),
    .REPEAT_RATE_CYC  (RR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up_n   (btn_up_n),
    .btn_dn_n   (btn_dn_n),
    .value      (value),
    .step_pulse (step_pulse),
    .step_dir   (step_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // m_mode: 0 = idle, 1 = held (press time in m_press_t), 2 = locked out
  logic        m_pin1 [2];
  logic        m_sync [2][D];
  logic        m_stab [2];
  logic        m_stab_prev [2];
  int          m_mode [2];
  int unsigned m_press_t [2];
  logic [2:0]  m_value;
  logic        m_pulse;
  logic        m_dir;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_pin1[b] = 1'b1;
      for (int k = 0; k < D; k++) m_sync[b][k] = 1'b1;
      m_stab[b] = 1'b1;
      m_stab_prev[b] = 1'b1;
      m_mode[b] = 0;
      m_press_t[b] = 0;
    end
    m_value = 3'd0;
    m_pulse = 1'b0;
    m_dir   = 1'b1;
  endtask

  // One clock edge; pins[0] = UP pin, pins[1] = DOWN pin as seen at the edge
  task automatic model_edge(input logic [1:0] pins);
    logic req [2];
    logic flip [2];
    logic both_low, pr, rl;
    int unsigned el;
    both_low = !m_stab[0] && !m_stab[1];
    for (int b = 0; b < 2; b++) begin
      // level accepted after D consecutive synchronised samples disagree
      flip[b] = 1'b1;
      for (int k = 0; k < D; k++) if (m_sync[b][k] == m_stab[b]) flip[b] = 1'b0;
      pr = m_stab_prev[b] && !m_stab[b];
      rl = !m_stab_prev[b] && m_stab[b];
      req[b] = 1'b0;
      if (both_low) begin
        m_mode[b] = 2;
      end else if (m_mode[b] == 1) begin
        if (rl) m_mode[b] = 0;
        else begin
          el = cyc - m_press_t[b];
          if (el >= RD && ((el - RD) % RR) == 0) req[b] = 1'b1;
        end
      end else if (m_mode[b] == 0) begin
        if (pr) begin
          req[b] = 1'b1;
          m_mode[b] = 1;
          m_press_t[b] = cyc;
        end
      end else begin
        if (rl) m_mode[b] = 0;
      end
    end
    m_pulse = 1'b0;
    if (req[0] && !req[1]) begin
      m_value = m_value + 3'd1; m_dir = 1'b1; m_pulse = 1'b1;
    end else if (req[1] && !req[0]) begin
      m_value = m_value - 3'd1; m_dir = 1'b0; m_pulse = 1'b1;
    end
    for (int b = 0; b < 2; b++) begin
      m_stab_prev[b] = m_stab[b];
      if (flip[b]) m_stab[b] = !m_stab[b];
      for (int k = D - 1; k > 0; k--) m_sync[b][k] = m_sync[b][k-1];
      m_sync[b][0] = m_pin1[b];
      m_pin1[b] = pins[b];
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    logic [1:0] p;
    p = {btn_dn_n, btn_up_n};
    @(posedge clk);
    #1;
    cyc++;
    if (rst) model_reset();
    else model_edge(p);
  endtask

  // Stimulus queue: {dn_pin, up_pin} per cycle
  logic [1:0] stim [$];

  task automatic push(input logic [1:0] lv, input int n);
    for (int k = 0; k < n; k++) stim.push_back(lv);
  endtask

  task automatic apply_reset();
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    rst = 1'b1;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (value !== 3'd0 || step_pulse !== 1'b0 || step_dir !== 1'b1) begin
      errors++;
      $display("FAIL reset_values got v=%0d p=%b d=%b exp v=0 p=0 d=1", value, step_pulse, step_dir);
    end
    rst = 1'b0;
    stim.delete();
    push(2'b11, 10);
    for (int k = 0; k < stim.size(); k++) begin
      {btn_dn_n, btn_up_n} = stim[k];
      tick();
      checks++;
      if (value !== 3'd0 || step_pulse !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got v=%0d p=%b exp v=0 p=0", cyc, value, step_pulse);
      end
    end
  endtask

  task automatic test_single_press();
    int unsigned n;
    int pulses;
    pulses = 0;
    stim.delete();
    push(2'b10, 12);
    push(2'b11, 25);
    n = cyc + 1;
    for (int k = 0; k < stim.size(); k++) begin
      {btn_dn_n, btn_up_n} = stim[k];
      tick();
      if (step_pulse === 1'b1) pulses++;
      checks++;
      if (step_pulse !== (cyc == n + D + 2)) begin
        errors++;
        $display("FAIL single_press_timing cyc=%0d got p=%b exp p=%b", cyc, step_pulse, (cyc == n + D + 2));
      end
      checks++;
      if ({value, step_pulse, step_dir} !== {m_value, m_pulse, m_dir}) begin
        errors++;
        $display("FAIL single_press_model cyc=%0d got v=%0d p=%b d=%b exp v=%0d p=%b d=%b",
                 cyc, value, step_pulse, step_dir, m_value, m_pulse, m_dir);
      end
    end
    checks++;
    if (value !== 3'd1 || step_dir !== 1'b1 || pulses != 1) begin
      errors++;
      $display("FAIL single_press_result got v=%0d d=%b pulses=%0d exp v=1 d=1 pulses=1", value, step_dir, pulses);
    end
  endtask

  task automatic test_glitch();
    logic [2:0] v0;
    v0 = m_value;
    stim.delete();
    push(2'b10, 3); push(2'b11, 1); push(2'b10, 3); push(2'b11, 20);
    for (int k = 0; k < stim.size(); k++) begin
      {btn_dn_n, btn_up_n} = stim[k];
      tick();
      checks++;
      if (step_pulse !== 1'b0 || value !== v0) begin
        errors++;
        $display("FAIL glitch cyc=%0d got v=%0d p=%b exp v=%0d p=0", cyc, value, step_pulse, v0);
      end
    end
  endtask

  task automatic test_down_repeat();
    int unsigned n;
    int unsigned offs [6];
    int idx;
    offs = '{0, 20, 28, 36, 44, 52};
    idx = 0;
    apply_reset();
    stim.delete();
    push(2'b01, 60);
    push(2'b11, 20);
    n = cyc + 1;
    for (int k = 0; k < stim.size(); k++) begin
      {btn_dn_n, btn_up_n} = stim[k];
      tick();
      if (step_pulse === 1'b1) begin
        checks++;
        if (idx >= 6 || cyc != n + D + 2 + offs[idx] || value !== 3'(7 - idx) || step_dir !== 1'b0) begin
          errors++;
          $display("FAIL down_repeat_step idx=%0d cyc=%0d got v=%0d d=%b exp cyc=%0d v=%0d d=0",
                   idx, cyc, value, step_dir, (idx < 6) ? n + D + 2 + offs[idx] : 0, 7 - idx);
        end
        idx++;
      end
      checks++;
      if ({value, step_pulse, step_dir} !== {m_value, m_pulse, m_dir}) begin
        errors++;
        $display("FAIL down_repeat_model cyc=%0d got v=%0d p=%b d=%b exp v=%0d p=%b d=%b",
                 cyc, value, step_pulse, step_dir, m_value, m_pulse, m_dir);
      end
    end
    checks++;
    if (idx != 6 || value !== 3'd2) begin
      errors++;
      $display("FAIL down_repeat_count got steps=%0d v=%0d exp steps=6 v=2", idx, value);
    end
  endtask

  task automatic test_both_locked();
    int unsigned t0;
    int locked_pulses, final_pulses;
    locked_pulses = 0;
    final_pulses = 0;
    apply_reset();
    stim.delete();
    push(2'b10, 40); push(2'b00, 30); push(2'b10, 30);
    push(2'b11, 10); push(2'b10, 8); push(2'b11, 20);
    t0 = cyc + 41;
    for (int k = 0; k < stim.size(); k++) begin
      {btn_dn_n, btn_up_n} = stim[k];
      tick();
      if (step_pulse === 1'b1 && cyc >= t0 + D + 2 && cyc < t0 + 70) locked_pulses++;
      if (step_pulse === 1'b1 && cyc >= t0 + 70) final_pulses++;
      checks++;
      if ({value, step_pulse, step_dir} !== {m_value, m_pulse, m_dir}) begin
        errors++;
        $display("FAIL both_locked_model cyc=%0d got v=%0d p=%b d=%b exp v=%0d p=%b d=%b",
                 cyc, value, step_pulse, step_dir, m_value, m_pulse, m_dir);
      end
    end
    checks++;
    if (locked_pulses != 0 || final_pulses != 1) begin
      errors++;
      $display("FAIL both_locked_counts got locked=%0d final=%0d exp locked=0 final=1", locked_pulses, final_pulses);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      stim.delete();
      push((i == 8) ? 2'b01 : 2'b10, 8);
      push(2'b11, 12);
      for (int k = 0; k < stim.size(); k++) begin
        {btn_dn_n, btn_up_n} = stim[k];
        tick();
      end
      checks++;
      if (value !== ((i == 8) ? 3'd7 : 3'((i + 1) % 8)) || step_dir !== (i != 8)) begin
        errors++;
        $display("FAIL wrap press=%0d got v=%0d d=%b exp v=%0d d=%b",
                 i, value, step_dir, (i == 8) ? 7 : (i + 1) % 8, (i != 8));
      end
    end
  endtask

  task automatic test_reset_mid();
    int unsigned r;
    logic exp_p;
    apply_reset();
    btn_up_n = 1'b0;
    repeat (D + 12) tick();
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (value !== 3'd0 || step_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async got v=%0d p=%b exp v=0 p=0", value, step_pulse);
    end
    repeat (3) begin
      tick();
      checks++;
      if (value !== 3'd0 || step_pulse !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_held cyc=%0d got v=%0d p=%b exp v=0 p=0", cyc, value, step_pulse);
      end
    end
    rst = 1'b0;
    r = cyc + 1;
    for (int k = 0; k < 50; k++) begin
      tick();
      exp_p = (cyc == r + D + 2) || (cyc == r + D + 2 + RD) ||
              (cyc == r + D + 2 + RD + RR) || (cyc == r + D + 2 + RD + 2 * RR);
      checks++;
      if (step_pulse !== exp_p || value !== m_value) begin
        errors++;
        $display("FAIL reset_mid_resume cyc=%0d got v=%0d p=%b exp v=%0d p=%b", cyc, value, step_pulse, m_value, exp_p);
      end
    end
    btn_up_n = 1'b1;
    repeat (20) tick();
  endtask

  task automatic test_random();
    int rem [2];
    logic lv [2];
    rem = '{0, 0};
    lv = '{1'b1, 1'b1};
    apply_reset();
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < 2; b++) begin
        if (rem[b] == 0) begin
          lv[b] = ($urandom_range(0, 2) != 0) ? ~lv[b] : lv[b];
          rem[b] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(50, 120)) : int'($urandom_range(1, 40));
        end
        rem[b]--;
      end
      btn_up_n = lv[0];
      btn_dn_n = lv[1];
      tick();
      checks++;
      if ({value, step_pulse, step_dir} !== {m_value, m_pulse, m_dir}) begin
        errors++;
        $display("FAIL random_model cyc=%0d got v=%0d p=%b d=%b exp v=%0d p=%b d=%b",
                 cyc, value, step_pulse, step_dir, m_value, m_pulse, m_dir);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    model_reset();
    test_reset();
    test_single_press();
    test_glitch();
    test_down_repeat();
    test_both_locked();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
